// File: rtl/bin2bcd_converter_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_converter_pkg
// Shared constants and types for the binary-to-BCD converter.
//   N_BITS         : default width of the binary operand (max 13 -> fits 4 digits)
//   DIGITS         : number of BCD output digits
//   ADD3_THRESHOLD : digits at or above this value get +3 before each shift
//   state_t        : converter FSM encoding (IDLE, OP, DONE)
// -----------------------------------------------------------------------------
package bin2bcd_converter_pkg;

    localparam int N_BITS = 13;
    localparam int DIGITS = 4;

    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bin2bcd_converter_add3.sv
// -----------------------------------------------------------------------------
// add3_adjust
// Combinational double-dabble digit correction: a BCD digit of 5 or more is
// bumped by 3 so that the following left shift carries correctly into the
// next decimal digit.
//   digit_in  : 4-bit working BCD digit (0..9)
//   digit_out : corrected digit (at most 12, so the 4-bit add cannot overflow)
// -----------------------------------------------------------------------------
module add3_adjust
    import bin2bcd_converter_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= ADD3_THRESHOLD) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bin2bcd_converter.sv
// -----------------------------------------------------------------------------
// bin2bcd_converter
// Sequential double-dabble binary-to-BCD converter. Sits between the
// difference engine (start <- done_tick, bin <- data_out) and the
// seven-segment display driver.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : conversion request, accepted only while ready
//   bin        : unsigned operand, sampled when start is accepted
//   ready      : high while idle
//   done_tick  : one-cycle pulse when bcd3..bcd0 carry a fresh result
//   bcd3..bcd0 : thousands/hundreds/tens/units, updated only on completion
// -----------------------------------------------------------------------------
module bin2bcd_converter #(
    parameter int N_BITS = bin2bcd_converter_pkg::N_BITS,
    parameter int DIGITS = bin2bcd_converter_pkg::DIGITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] bin,
    output logic              ready,
    output logic              done_tick,
    output logic [3:0]        bcd3,
    output logic [3:0]        bcd2,
    output logic [3:0]        bcd1,
    output logic [3:0]        bcd0
);

    import bin2bcd_converter_pkg::*;

    localparam int CNT_W = $clog2(N_BITS + 1);
    localparam int BCD_W = 4 * DIGITS;

    state_t state_reg, state_next;

    logic [N_BITS-1:0] shift_reg, shift_next;
    logic [BCD_W-1:0]  work_reg,  work_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    logic [BCD_W-1:0]  bcd_reg,   bcd_next;

    // Working digits after the per-digit +3 correction.
    logic [BCD_W-1:0]  work_adj;

    // {corrected BCD, remaining binary} shifted left by one: one OP step.
    logic [BCD_W+N_BITS-1:0] op_shift;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adjust
            add3_adjust u_add3 (
                .digit_in  (work_reg[4*gi +: 4]),
                .digit_out (work_adj[4*gi +: 4])
            );
        end
    endgenerate

    assign op_shift = {work_adj, shift_reg} << 1;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            work_reg  <= '0;
            cnt_reg   <= '0;
            bcd_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            work_reg  <= work_next;
            cnt_reg   <= cnt_next;
            bcd_reg   <= bcd_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        work_next  = work_reg;
        cnt_next   = cnt_reg;
        bcd_next   = bcd_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    shift_next = bin;
                    work_next  = '0;
                    cnt_next   = CNT_W'(N_BITS);
                    state_next = OP;
                end
            end

            OP: begin
                work_next  = op_shift[BCD_W+N_BITS-1:N_BITS];
                shift_next = op_shift[N_BITS-1:0];
                cnt_next   = cnt_reg - CNT_W'(1);
                // Last shift: publish the finished digits on the same edge we
                // enter DONE, so the display never sees an intermediate value.
                if (cnt_reg == CNT_W'(1)) begin
                    bcd_next   = op_shift[BCD_W+N_BITS-1:N_BITS];
                    state_next = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ready     = (state_reg == IDLE);
    assign done_tick = (state_reg == DONE);

    assign bcd3 = bcd_reg[15:12];
    assign bcd2 = bcd_reg[11:8];
    assign bcd1 = bcd_reg[7:4];
    assign bcd0 = bcd_reg[3:0];

endmodule

// File: tb/tb_bin2bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_converter
// Self-checking bench: a cycle-timing/decimal reference model is compared with
// the DUT on every falling edge, with directed scenarios and a random sweep.
// -----------------------------------------------------------------------------
module tb_bin2bcd_converter;

    localparam int N_BITS = 13;
    localparam int DIGITS = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [N_BITS-1:0] bin;
    logic              ready;
    logic              done_tick;
    logic [3:0]        bcd3, bcd2, bcd1, bcd0;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bin2bcd_converter #(
        .N_BITS (N_BITS),
        .DIGITS (DIGITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin       (bin),
        .ready     (ready),
        .done_tick (done_tick),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0)
    );

    // Decimal digits of v via plain arithmetic.
    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a request seen while idle is accepted; the result
    // appears N_BITS edges later for exactly one cycle, then the block is
    // idle again one edge after that. Requests while busy are dropped.
    // ------------------------------------------------------------------
    bit          m_busy;
    int          m_elapsed;
    int          m_val;
    bit          m_done;
    logic [15:0] m_digits;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy    <= 1'b0;
            m_elapsed <= 0;
            m_val     <= 0;
            m_done    <= 1'b0;
            m_digits  <= '0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy    <= 1'b1;
                m_val     <= int'(bin);
                m_elapsed <= 0;
            end
        end else begin
            m_elapsed <= m_elapsed + 1;
            if (m_elapsed + 1 == N_BITS) begin
                m_done   <= 1'b1;
                m_digits <= to_bcd(m_val);
            end else if (m_elapsed + 1 == N_BITS + 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_outputs", {ready, done_tick, bcd3, bcd2, bcd1, bcd0},
                  {!m_busy, m_done, m_digits});
            check("digit_range", (bcd3 <= 4'd9) && (bcd2 <= 4'd9) && (bcd1 <= 4'd9) && (bcd0 <= 4'd9), 1);
        end
    end

    // Returns just after the accepting edge.
    task automatic pulse_start(input int v);
        @(posedge clk);
        #1;
        bin   = N_BITS'(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits on falling edges for done_tick; n = falling edges waited (0 on timeout).
    // With scramble set, bin and start are randomised while the conversion runs.
    task automatic wait_done(input string name, input bit scramble, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done_tick) begin
                n = i;
                break;
            end
            if (scramble) begin
                @(posedge clk);
                #1;
                bin   = N_BITS'($urandom);
                start = 1'($urandom_range(0, 1));
            end
        end
        if (n == 0) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        int last;
        int v;

        reset = 1'b0;
        start = 1'b0;
        bin   = '0;
        chk_en = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready",  ready, 1);
        check("rst_done",   done_tick, 0);
        check("rst_digits", {bcd3, bcd2, bcd1, bcd0}, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Zero operand: latency and ready return
        pulse_start(0);
        wait_done("bin0", 1'b0, n);
        check("latency_bin0", n, N_BITS + 1);
        check("digits_bin0", {bcd3, bcd2, bcd1, bcd0}, 16'h0000);
        $display("[TB] conv bin=0 -> %0d%0d%0d%0d after %0d cycles", bcd3, bcd2, bcd1, bcd0, n);
        @(negedge clk);
        check("ready_after_done", ready, 1);

        // Maximum operand, then a second value while the first is held
        pulse_start(8191);
        wait_done("bin8191", 1'b0, n);
        check("digits_8191", {bcd3, bcd2, bcd1, bcd0}, 16'h8191);
        check("model_8191", m_digits, 16'h8191);
        $display("[TB] conv bin=8191 -> %0d%0d%0d%0d", bcd3, bcd2, bcd1, bcd0);
        pulse_start(1234);
        @(negedge clk);
        check("held_8191", {bcd3, bcd2, bcd1, bcd0}, 16'h8191);
        wait_done("bin1234", 1'b0, n);
        check("digits_1234", {bcd3, bcd2, bcd1, bcd0}, 16'h1234);
        $display("[TB] conv bin=1234 -> %0d%0d%0d%0d", bcd3, bcd2, bcd1, bcd0);

        // Start pulses during OP are ignored and bin changes do not leak in
        pulse_start(4095);
        bin = N_BITS'(7);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_tick) begin
                cnt++;
                check("digits_4095", {bcd3, bcd2, bcd1, bcd0}, 16'h4095);
            end
        end
        check("single_done_4095", cnt, 1);
        $display("[TB] conv bin=4095 with ignored starts -> %0d%0d%0d%0d, %0d done", bcd3, bcd2, bcd1, bcd0, cnt);

        // Reset in the middle of a conversion
        pulse_start(999);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_ready",  ready, 1);
        check("midrst_done",   done_tick, 0);
        check("midrst_digits", {bcd3, bcd2, bcd1, bcd0}, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_tick) cnt++;
        end
        check("midrst_no_done", cnt, 0);
        pulse_start(999);
        wait_done("bin999", 1'b0, n);
        check("digits_999", {bcd3, bcd2, bcd1, bcd0}, 16'h0999);
        $display("[TB] conv bin=999 after reset -> %0d%0d%0d%0d", bcd3, bcd2, bcd1, bcd0);

        // Start held high: back-to-back conversions every N_BITS+2 cycles
        @(posedge clk);
        #1;
        bin   = N_BITS'(5);
        start = 1'b1;
        cnt   = 0;
        last  = 0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (done_tick) begin
                if (cnt > 0) check("repeat_period", i - last, N_BITS + 2);
                check("digits_5", {bcd3, bcd2, bcd1, bcd0}, 16'h0005);
                cnt++;
                last = i;
            end
        end
        check("repeat_count", cnt, 4);
        $display("[TB] conv bin=5 held start -> %0d conversions", cnt);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);

        // Random sweep with bin/start noise during each conversion
        for (int k = 0; k < 1000; k++) begin
            v = int'($urandom_range(0, 8191));
            pulse_start(v);
            wait_done("rand", 1'b1, n);
            check("digits_rand", {bcd3, bcd2, bcd1, bcd0}, to_bcd(v));
            $display("[TB] conv bin=%0d -> %0d%0d%0d%0d", v, bcd3, bcd2, bcd1, bcd0);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bin2bcd_converter.md
BIN2BCD_CONVERTER -- requirements
Module: bin2bcd_converter

Interface
REQ-001 Parameter N_BITS, default 13: width of the binary operand. Legal range 1..13, so the result always fits in 4 BCD digits.
REQ-002 Parameter DIGITS, default 4: number of BCD output digits. Fixed at 4.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = asserted).
REQ-005 start  input  1  conversion request; driven directly by the difference engine's done_tick.
REQ-006 bin  input  N_BITS  unsigned binary operand (the difference engine's data_out); sampled only when start is accepted.
REQ-007 ready  output  1  high while idle and able to accept start.
REQ-008 done_tick  output  1  one-cycle pulse when a new result is valid.
REQ-009 bcd3, bcd2, bcd1, bcd0  output  4 each  thousands, hundreds, tens and units digits, registered.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, OP, DONE.
REQ-011 In IDLE, ready SHALL be 1; in OP and DONE, ready SHALL be 0.
REQ-012 IDLE with start=1 SHALL, at the next edge: load bin into the internal shift register, clear the 16-bit working BCD register, set the iteration counter to N_BITS, and go to OP.
REQ-013 Each OP cycle SHALL first add 3 to every working digit that is >=5, then shift {working BCD, shift register} left by one, and decrement the counter.
REQ-014 OP SHALL go to DONE on the edge where the counter reaches 0, i.e. after exactly N_BITS OP cycles.
REQ-015 On entry to DONE, the working BCD register SHALL be copied to bcd3..bcd0.
REQ-016 done_tick SHALL be 1 only while in DONE, which lasts exactly one cycle before returning to IDLE.
REQ-017 Latency: with start sampled at edge E0, done_tick SHALL be high in the cycle after edge E0+N_BITS, which is N_BITS+1 cycles after start.
REQ-018 bcd3..bcd0 SHALL hold their last value through IDLE and OP; they change only on entry to DONE, so the display never shows partial results.
REQ-019 start SHALL be ignored in OP and in DONE; no request is queued.
REQ-020 bin changing during OP SHALL NOT affect the result.
REQ-021 Every output digit SHALL be in the range 0..9.
REQ-022 Result for bin = 2^N_BITS-1 SHALL be exact; for N_BITS=13, 8191 gives 8,1,9,1.
REQ-023 All arithmetic SHALL be unsigned. Add-3 is per digit, 4 bits wide, and never overflows because the digit is <=9 before the add.

Reset
REQ-024 reset=0 SHALL immediately (asynchronously) force: state IDLE, ready=1, done_tick=0, bcd3..bcd0=0, working and shift registers 0, counter 0.
REQ-025 reset asserted mid-OP SHALL abort the conversion; no done_tick SHALL be produced for it.
REQ-026 After reset deasserts, the first start in IDLE SHALL be accepted normally.

Structure
REQ-027 A shared package SHALL hold: N_BITS, DIGITS, the state encoding (IDLE, OP, DONE), and the add-3 threshold constant (5).
REQ-028 The per-digit "if >=5 add 3" logic SHALL be one combinational sub-module, add3_adjust (4-bit in, 4-bit out), instantiated DIGITS times.
REQ-029 The block SHALL sit between Difference_Engine and display: start from done_tick, bin from data_out, and digits forward to the seven-segment driver.

Verification
REQ-030 bin=0, start pulse -> done_tick 14 cycles after start; digits 0,0,0,0; ready back to 1 on the following cycle.
REQ-031 bin=8191, start -> digits 8,1,9,1. Then bin=1234, start -> digits 1,2,3,4, with 8,1,9,1 held until that done_tick.
REQ-032 bin=4095, start; then bin=7 with start pulsed at cycles 3 and 13 of OP -> single done_tick with 4,0,9,5; no second conversion follows.
REQ-033 bin=999, start; reset=0 asserted at OP cycle 6 -> outputs 0 immediately, ready=1, no done_tick; then bin=999 with start after release -> 0,9,9,9.
REQ-034 Start held high continuously with bin=5 -> conversions repeat every N_BITS+2 cycles, each giving 0,0,0,5, with a one-cycle done_tick each time.
REQ-035 Random sweep of 1000 values in 0..8191 -> digits match a decimal reference model, and every digit stays <=9.
